// File: rtl/enc_binder_array.sv
// rtl/enc_binder_array.sv - time-multiplexed binder array for the sparse HDC encoder
// Latches one bundle, rotates LANES features per pass, holds the bound bundle until accepted.
module enc_binder_array #(
   parameter int HV_DIM       = 2048,
   parameter int N_FEAT       = 8,
   parameter int LANES        = 4,
   parameter int SEG_LEN      = 64,
   parameter int SHIFT_STRIDE = 1,
   parameter int OFF_W        = $clog2(HV_DIM)
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              abort,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [HV_DIM-1:0] level_hv [0:N_FEAT-1],
   input  logic [N_FEAT-1:0] feature_en,
   input  logic              mode,
   input  logic              unbind,
   input  logic [OFF_W-1:0]  shift_offset,
   output logic [HV_DIM-1:0] shifted_hv [0:N_FEAT-1],
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy
);

   localparam int PASSES = (N_FEAT + LANES - 1) / LANES;
   localparam int PW     = (PASSES > 1) ? $clog2(PASSES) : 1;
   localparam int N_SEG  = HV_DIM / SEG_LEN;

   typedef enum logic [1:0] {IDLE, BIND, DONE} state_t;

   state_t              state_q;
   logic [PW-1:0]       pass_q;
   logic [HV_DIM-1:0]   level_q   [0:N_FEAT-1];
   logic [HV_DIM-1:0]   shifted_q [0:N_FEAT-1];
   logic [N_FEAT-1:0]   en_q;
   logic                mode_q;
   logic                unbind_q;
   logic [OFF_W-1:0]    offset_q;

   int                  lane_idx  [LANES];
   int                  lane_amt  [LANES];
   logic [HV_DIM-1:0]   lane_src  [LANES];
   logic [HV_DIM-1:0]   lane_rot  [LANES];
   logic [HV_DIM-1:0]   lane_hv_d [LANES];
   logic [LANES-1:0]    lane_en;

   // Shift amount is formed in 32-bit arithmetic so offset + i*stride never wraps before the mod.
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         lane_idx[l] = int'(pass_q) * LANES + l;
         lane_src[l] = '0;
         lane_en[l]  = 1'b0;
         for (int f = 0; f < N_FEAT; f++) begin
            if (lane_idx[l] == f) begin
               lane_src[l] = level_q[f];
               lane_en[l]  = en_q[f];
            end
         end
         lane_amt[l] = int'(offset_q) + lane_idx[l] * SHIFT_STRIDE;
         lane_amt[l] = mode_q ? (lane_amt[l] % SEG_LEN) : (lane_amt[l] % HV_DIM);
         if (unbind_q)
            lane_amt[l] = mode_q ? ((SEG_LEN - lane_amt[l]) % SEG_LEN)
                                 : ((HV_DIM - lane_amt[l]) % HV_DIM);
         lane_rot[l] = '0;
         if (mode_q) begin
            for (int k = 0; k < N_SEG; k++)
               lane_rot[l][k*SEG_LEN +: SEG_LEN] =
                  (lane_src[l][k*SEG_LEN +: SEG_LEN] << lane_amt[l]) |
                  (lane_src[l][k*SEG_LEN +: SEG_LEN] >> (SEG_LEN - lane_amt[l]));
         end else begin
            lane_rot[l] = (lane_src[l] << lane_amt[l]) | (lane_src[l] >> (HV_DIM - lane_amt[l]));
         end
         lane_hv_d[l] = lane_en[l] ? lane_rot[l] : '0;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q  <= IDLE;
         pass_q   <= '0;
         en_q     <= '0;
         mode_q   <= 1'b0;
         unbind_q <= 1'b0;
         offset_q <= '0;
         for (int f = 0; f < N_FEAT; f++) begin
            level_q[f]   <= '0;
            shifted_q[f] <= '0;
         end
      end else if (abort) begin
         state_q <= IDLE;
         pass_q  <= '0;
         for (int f = 0; f < N_FEAT; f++)
            shifted_q[f] <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  level_q  <= level_hv;
                  en_q     <= feature_en;
                  mode_q   <= mode;
                  unbind_q <= unbind;
                  offset_q <= shift_offset;
                  pass_q   <= '0;
                  state_q  <= BIND;
               end
            end
            BIND: begin
               // Lanes whose feature index runs past N_FEAT match no entry and write nothing.
               for (int l = 0; l < LANES; l++)
                  for (int f = 0; f < N_FEAT; f++)
                     if (lane_idx[l] == f)
                        shifted_q[f] <= lane_hv_d[l];
               if (int'(pass_q) == PASSES - 1) begin
                  pass_q  <= '0;
                  state_q <= DONE;
               end else begin
                  pass_q <= pass_q + 1'b1;
               end
            end
            DONE: begin
               if (out_ready)
                  state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign shifted_hv = shifted_q;
   assign in_ready   = (state_q == IDLE);
   assign out_valid  = (state_q == DONE);
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_enc_binder_array.sv
// tb/tb_enc_binder_array.sv - scoreboard bench for enc_binder_array
// Directed bundles push hand-computed expectations; a negedge monitor pops them on each output handshake.
module tb_enc_binder_array;

   localparam int HV_DIM = 64;
   localparam int N_FEAT = 8;

   logic        clk = 1'b0;
   logic        nrst;
   logic        abort;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] level_hv   [0:N_FEAT-1];
   logic [7:0]  feature_en;
   logic        mode;
   logic        unbind;
   logic [5:0]  shift_offset;
   logic [63:0] shifted_hv [0:N_FEAT-1];
   logic        out_valid;
   logic        out_ready;
   logic        busy;

   int n_pass  = 0;
   int n_total = 0;

   logic [7:0][63:0] exp_q [$];
   logic [7:0][63:0] lv, ex, bund;

   enc_binder_array #(
      .HV_DIM(64), .N_FEAT(8), .LANES(3), .SEG_LEN(16), .SHIFT_STRIDE(1), .OFF_W(6)
   ) dut (
      .clk(clk), .nrst(nrst), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
      .level_hv(level_hv), .feature_en(feature_en), .mode(mode), .unbind(unbind),
      .shift_offset(shift_offset), .shifted_hv(shifted_hv), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h expected=%h", name, act, exp);
   endtask

   task automatic scramble();
      for (int f = 0; f < N_FEAT; f++) level_hv[f] = {$urandom, $urandom};
   endtask

   task automatic send(input logic m, input logic u, input logic [5:0] off, input logic [7:0] en,
                       input logic [7:0][63:0] lvec, input logic [7:0][63:0] evec, input bit push);
      int t = 0;
      mode = m; unbind = u; shift_offset = off; feature_en = en;
      for (int f = 0; f < N_FEAT; f++) level_hv[f] = lvec[f];
      in_valid = 1'b1;
      while (!in_ready && t < 200) begin
         @(posedge clk); #1; t++;
      end
      if (t >= 200) begin
         n_total++;
         $display("FAIL send_timeout actual=in_ready_low expected=in_ready_high");
      end
      @(posedge clk);
      if (push) exp_q.push_back(evec);
      #1;
      in_valid = 1'b0;
      // Post-accept input changes must not reach the bound result.
      scramble();
      mode = $urandom_range(0, 1); unbind = $urandom_range(0, 1);
      shift_offset = 6'($urandom); feature_en = 8'($urandom);
   endtask

   always @(negedge clk) begin
      if (nrst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_output actual=out_valid expected=no_output");
         end else begin
            bund = exp_q.pop_front();
            for (int f = 0; f < N_FEAT; f++)
               chk($sformatf("out[%0d]", f), shifted_hv[f], bund[f]);
         end
      end
   end

   initial begin
      int t;
      nrst = 1'b0; abort = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      mode = 1'b1; unbind = 1'b1; shift_offset = 6'd9; feature_en = 8'hA5;
      scramble();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      for (int f = 0; f < N_FEAT; f++) chk($sformatf("rst_hv[%0d]", f), shifted_hv[f], 64'd0);
      in_valid = 1'b0;
      @(posedge clk); #1; nrst = 1'b1;

      // Basic bind with latency: accept in cycle 0, out_valid first in cycle 4.
      for (int f = 0; f < N_FEAT; f++) begin lv[f] = 64'h1; ex[f] = 64'h1 << f; end
      send(1'b0, 1'b0, 6'd0, 8'hFF, lv, ex, 1'b1);
      for (int c = 1; c <= 4; c++) begin
         if (c > 1) @(posedge clk);
         @(negedge clk);
         chk($sformatf("lat_out_valid_c%0d", c), 64'(out_valid), (c == 4) ? 64'd1 : 64'd0);
         if (c == 1) chk("lat_busy_c1", 64'(busy), 64'd1);
      end

      // Unbind, offset 5, feature 2 masked: bit (59 - i).
      for (int f = 0; f < N_FEAT; f++) begin
         lv[f] = 64'h1;
         ex[f] = (f == 2) ? 64'h0 : (64'h1 << (59 - f));
      end
      send(1'b0, 1'b1, 6'd5, 8'hFB, lv, ex, 1'b1);

      // Bind the unbound result again: identity, masked feature stays zero.
      lv = ex;
      for (int f = 0; f < N_FEAT; f++) ex[f] = (f == 2) ? 64'h0 : 64'h1;
      send(1'b0, 1'b0, 6'd5, 8'hFF, lv, ex, 1'b1);

      // Segmented wrap, offset 15, bit 15 in: bit (14 + i) mod 16, never leaves segment 0.
      for (int f = 0; f < N_FEAT; f++) begin
         lv[f] = 64'h8000;
         ex[f] = 64'h1 << ((14 + f) % 16);
      end
      send(1'b1, 1'b0, 6'd15, 8'hFF, lv, ex, 1'b1);

      // Same in all four segments: each segment rotates independently.
      for (int f = 0; f < N_FEAT; f++) begin
         lv[f] = 64'h8000_8000_8000_8000;
         ex[f] = {4{16'h1 << ((14 + f) % 16)}};
      end
      send(1'b1, 1'b0, 6'd15, 8'hFF, lv, ex, 1'b1);

      // Full-width wrap, offset 63: offset + i exceeds 63, bit 63 lands at (62 + i) mod 64.
      for (int f = 0; f < N_FEAT; f++) begin
         lv[f] = 64'h8000_0000_0000_0000;
         ex[f] = 64'h1 << ((62 + f) % 64);
      end
      send(1'b0, 1'b0, 6'd63, 8'hFF, lv, ex, 1'b1);

      // Backpressure: ten held cycles with in_valid high and changing level_hv.
      for (int f = 0; f < N_FEAT; f++) begin lv[f] = 64'h1; ex[f] = 64'h1 << f; end
      send(1'b0, 1'b0, 6'd0, 8'hFF, lv, ex, 1'b1);
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int c = 0; c < 10; c++) begin
         in_valid = 1'b1;
         scramble();
         @(negedge clk);
         chk("bp_out_valid", 64'(out_valid), 64'd1);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_hv0", shifted_hv[0], 64'h1);
         chk("bp_hv7", shifted_hv[7], 64'h80);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_release_in_ready", 64'(in_ready), 64'd1);
      chk("bp_release_out_valid", 64'(out_valid), 64'd0);

      // Abort in IDLE beats a simultaneous accept.
      in_valid = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("abort_idle_busy", 64'(busy), 64'd0);

      // Abort during pass 1.
      for (int f = 0; f < N_FEAT; f++) lv[f] = {$urandom, $urandom} | 64'h1;
      send(1'b0, 1'b0, 6'd3, 8'hFF, lv, ex, 1'b0);
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_in_ready", 64'(in_ready), 64'd1);
      chk("abort_out_valid_c3", 64'(out_valid), 64'd0);
      for (int f = 0; f < N_FEAT; f++) chk($sformatf("abort_hv[%0d]", f), shifted_hv[f], 64'd0);
      @(posedge clk); @(negedge clk);
      chk("abort_out_valid_c4", 64'(out_valid), 64'd0);

      // Reset during pass 1.
      send(1'b0, 1'b0, 6'd3, 8'hFF, lv, ex, 1'b0);
      @(posedge clk); #1;
      nrst = 1'b0;
      #1;
      chk("nrst_busy", 64'(busy), 64'd0);
      chk("nrst_in_ready", 64'(in_ready), 64'd1);
      chk("nrst_out_valid", 64'(out_valid), 64'd0);
      for (int f = 0; f < N_FEAT; f++) chk($sformatf("nrst_hv[%0d]", f), shifted_hv[f], 64'd0);
      @(posedge clk); #1;
      nrst = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("nrst_out_valid_after", 64'(out_valid), 64'd0);

      // Recovery bundle after reset.
      for (int f = 0; f < N_FEAT; f++) begin lv[f] = 64'h3; ex[f] = 64'h3 << (f + 2); end
      send(1'b0, 1'b0, 6'd2, 8'hFF, lv, ex, 1'b1);

      t = 0;
      while (exp_q.size() > 0 && t < 100) begin @(posedge clk); t++; end
      if (exp_q.size() > 0) begin
         n_total++;
         $display("FAIL drain_timeout actual=%0d_pending expected=0_pending", exp_q.size());
      end
      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/enc_binder_array.md
# enc_binder_array

Parametrised, time-multiplexed binder array for the sparse HDC encoder. It accepts one bundle of `N_FEAT` level hypervectors through a valid/ready handshake. Each feature's vector is cyclically shifted (bound) by a per-feature amount, using `LANES` physical shifters over several passes. The bound bundle is held in an output register until the downstream accumulator accepts it. The block adds runtime offset, unbind direction, segment-wise rotation for block-sparse codes, a feature-enable mask and abort.

## Interface
- `HV_DIM`, 2048: hypervector width in bits.
- `N_FEAT`, 8: features per bundle.
- `LANES`, 4: physical shifters; `PASSES = ceil(N_FEAT/LANES)`.
- `SEG_LEN`, 64: segment length for segmented mode; must divide `HV_DIM`.
- `SHIFT_STRIDE`, 1: shift increment between consecutive features.
- `OFF_W`, `$clog2(HV_DIM)`: offset width.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `nrst`, in, 1: asynchronous, active-low reset.
- `abort`, in, 1: synchronous flush, highest priority after reset.
- `in_valid`, in, 1: bundle and controls valid.
- `in_ready`, out, 1: block can accept a bundle.
- `level_hv[0:N_FEAT-1]`, in, `HV_DIM` each: level hypervectors.
- `feature_en`, in, `N_FEAT`: per-feature enable; a disabled feature outputs all-zero.
- `mode`, in, 1: 0 = full rotation over `HV_DIM`; 1 = independent rotation within each `SEG_LEN` segment.
- `unbind`, in, 1: 0 = rotate toward MSB; 1 = rotate toward LSB.
- `shift_offset`, in, `OFF_W`: global offset added to every feature's shift.
- `shifted_hv[0:N_FEAT-1]`, out, `HV_DIM` each: registered bound vectors.
- `out_valid`, out, 1: `shifted_hv` holds a complete bundle.
- `out_ready`, in, 1: downstream accepts.
- `busy`, out, 1: state is not IDLE.

## Operation
- States:
  - IDLE: `in_ready=1`.
  - BIND: pass counter `p` runs from 0 to `PASSES-1`.
  - DONE: `out_valid=1`.
- IDLE to BIND on `in_valid && in_ready`. All inputs except handshakes are latched on that cycle; later changes are ignored.
- Each BIND cycle processes features `i = p*LANES + l`, for `l` in `0..LANES-1`. Lanes with `i >= N_FEAT` are idle and write nothing.
- BIND to DONE after pass `PASSES-1`.
- DONE to IDLE on `out_ready`.
- Shift amount:
  - `D = HV_DIM` when `mode=0`; `D = SEG_LEN` when `mode=1`.
  - `s_i = (shift_offset + i*SHIFT_STRIDE) mod D`.
  - Compute at full width; truncate nothing before the mod.
- `unbind=0`:
  - Mode 0: input bit j goes to output bit `(j+s_i) mod HV_DIM`.
  - Mode 1: bit `k*SEG_LEN+j` goes to `k*SEG_LEN+((j+s_i) mod SEG_LEN)`; no bit crosses a segment boundary.
- `unbind=1`: same mappings with `-s_i`. Bind followed by unbind with equal controls is the identity.
- `feature_en[i]=0` forces `shifted_hv[i]` to zero.
- `abort`: next state IDLE, `shifted_hv` cleared to zero, `out_valid=0`. An accept in the same cycle is ignored.
- The multiplier `i*SHIFT_STRIDE` may be replaced by a per-lane accumulator, provided results match the formula.

## Timing
- Reset values:
  - State IDLE.
  - All `shifted_hv` = 0.
  - `out_valid=0`, `busy=0`, `in_ready=1`.
- `in_ready` and `out_valid` are decoded from state: `in_ready = IDLE`, `out_valid = DONE`.
- Accept at cycle 0. BIND runs in cycles 1..`PASSES`. `out_valid` rises in cycle `PASSES+1`.
- Earliest next accept is cycle `PASSES+2`. Minimum bundle period is `PASSES+2`.
- `shifted_hv` entries written in pass p are stable from cycle p+2. They are not modified while `out_valid=1`.
- In DONE with `out_ready=0`, outputs hold indefinitely. `in_valid` has no effect.
- `nrst` low mid-operation: immediate return to reset values; the bundle is lost.

## Test plan
All scenarios use `HV_DIM=64`, `N_FEAT=8`, `LANES=3` (`PASSES=3`), `SEG_LEN=16`, `SHIFT_STRIDE=1`.
- **Reset:** `nrst` low with random inputs -> `shifted_hv` all 0, `out_valid=0`, `busy=0`, `in_ready=1`.
- **Basic bind:** `mode=0`, `unbind=0`, offset 0, all `level_hv=64'h1`, `feature_en=8'hFF`; accept at cycle 0 -> `out_valid` at cycle 4, `shifted_hv[i]=1<<i`, `shifted_hv[7]=64'h80`.
- **Unbind and mask:** `unbind=1`, offset 5, `level_hv=64'h1`, `feature_en=8'hFB` -> `shifted_hv[0]` has bit 59 set, `shifted_hv[1]` bit 58, `shifted_hv[2]=0`; a second pass with `unbind=0` on the result restores `64'h1`.
- **Segmented wrap:** `mode=1`, offset 15, `level_hv=64'h8000` (bit 15) -> `shifted_hv[0]` bit 14, `shifted_hv[1]` bit 15, `shifted_hv[2]` bit 0; bit 16 is never set.
- **Backpressure:** `out_ready=0` for 10 cycles with `in_valid=1` and changing `level_hv` -> `out_valid` held, data stable, `in_ready=0`; release -> IDLE next cycle, next accept at cycle 5.
- **Abort:** `abort` in cycle 2 (pass 1) -> IDLE in cycle 3, `out_valid` never asserted, `shifted_hv` all 0; repeat using `nrst` low in cycle 2 -> same result.
